// File: rtl/mips_ctrl_pkg.sv
// Shared opcode constants, ALU operation classes and control-bundle types for the
// MIPS decode stage.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_SLT   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_LUI   = 3'b110
  } aluop_t;

  // Controls that travel into the E stage.
  typedef struct packed {
    logic   regwrite;
    logic   memtoreg;
    logic   memwrite;
    logic   alusrc;
    logic   regdst;
    logic   branch;
    logic   bne;
    logic   jal;
    logic   zeroext;
    aluop_t aluop;
  } ectrl_t;

  // Full decode bundle: E-stage controls plus the fetch redirects consumed in D.
  typedef struct packed {
    ectrl_t e;
    logic   jump;
    logic   jr;
  } ctrl_t;

  localparam ectrl_t E_NOP = '{
    regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0, alusrc: 1'b0, regdst: 1'b0,
    branch: 1'b0, bne: 1'b0, jal: 1'b0, zeroext: 1'b0, aluop: ALU_ADD
  };

  localparam ctrl_t CTRL_NOP = '{e: E_NOP, jump: 1'b0, jr: 1'b0};

  // Instructions whose rt field is a source operand rather than a destination.
  function automatic logic uses_rt(input logic [5:0] op, input logic [5:0] funct);
    logic r;
    case (op)
      OP_RTYPE:              r = (funct != FUNCT_JR);
      OP_SW, OP_BEQ, OP_BNE: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main decoder: opcode/funct to control bundle, with an illegal flag
// in place of don't-care outputs.
module ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Opcode table; anything unlisted leaves the bundle at zero.
  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          ctrl.jr = 1'b1;
        end else begin
          ctrl.e.regwrite = 1'b1;
          ctrl.e.regdst   = 1'b1;
          ctrl.e.aluop    = ALU_FUNCT;
        end
      end
      OP_LW: begin
        ctrl.e.regwrite = 1'b1;
        ctrl.e.alusrc   = 1'b1;
        ctrl.e.memtoreg = 1'b1;
        ctrl.e.aluop    = ALU_ADD;
      end
      OP_SW: begin
        ctrl.e.alusrc   = 1'b1;
        ctrl.e.memwrite = 1'b1;
        ctrl.e.aluop    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.e.branch = 1'b1;
        ctrl.e.aluop  = ALU_SUB;
      end
      OP_BNE: begin
        ctrl.e.branch = 1'b1;
        ctrl.e.bne    = 1'b1;
        ctrl.e.aluop  = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.e.regwrite = 1'b1;
        ctrl.e.alusrc   = 1'b1;
        ctrl.e.aluop    = ALU_ADD;
      end
      OP_SLTI: begin
        ctrl.e.regwrite = 1'b1;
        ctrl.e.alusrc   = 1'b1;
        ctrl.e.aluop    = ALU_SLT;
      end
      OP_ANDI: begin
        if (EXT_OPS != 0) begin
          ctrl.e.regwrite = 1'b1;
          ctrl.e.alusrc   = 1'b1;
          ctrl.e.zeroext  = 1'b1;
          ctrl.e.aluop    = ALU_AND;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_ORI: begin
        if (EXT_OPS != 0) begin
          ctrl.e.regwrite = 1'b1;
          ctrl.e.alusrc   = 1'b1;
          ctrl.e.zeroext  = 1'b1;
          ctrl.e.aluop    = ALU_OR;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LUI: begin
        if (EXT_OPS != 0) begin
          ctrl.e.regwrite = 1'b1;
          ctrl.e.alusrc   = 1'b1;
          ctrl.e.aluop    = ALU_LUI;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.e.jal      = 1'b1;
        ctrl.e.regwrite = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ctrl_pipe.sv
// Decode-stage control with load-use / JR hazard detection, the ID/EX control
// register, a sticky illegal-opcode flag and a saturating stall counter.
module id_ctrl_pipe
  import mips_ctrl_pkg::*;
#(
  parameter int REGBITS = 5,
  parameter int EXT_OPS = 1,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr_d,
  input  logic               instr_valid_d,
  input  logic               flush_e,
  input  logic               memtoreg_m,
  input  logic               regwrite_m,
  input  logic [REGBITS-1:0] writereg_m,
  output logic               stall_f,
  output logic               stall_d,
  output logic               jump_d,
  output logic               jr_d,
  output logic               valid_e,
  output logic               regwrite_e,
  output logic               memtoreg_e,
  output logic               memwrite_e,
  output logic               alusrc_e,
  output logic               regdst_e,
  output logic               branch_e,
  output logic               bne_e,
  output logic               jal_e,
  output logic               zeroext_e,
  output logic [2:0]         aluop_e,
  output logic [REGBITS-1:0] rs_e,
  output logic [REGBITS-1:0] rt_e,
  output logic [REGBITS-1:0] rd_e,
  output logic [REGBITS-1:0] writereg_e,
  output logic               illegal_d,
  output logic               illegal_err,
  output logic [CNTW-1:0]    stall_cnt
);

  localparam logic [REGBITS-1:0] REG_ZERO = {REGBITS{1'b0}};
  localparam logic [REGBITS-1:0] REG_LINK = {REGBITS{1'b1}};
  localparam logic [CNTW-1:0]    CNT_MAX  = {CNTW{1'b1}};
  localparam logic [CNTW-1:0]    CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

  logic [5:0]         op_s;
  logic [5:0]         funct_s;
  logic [REGBITS-1:0] instr_rs_s;
  logic [REGBITS-1:0] instr_rt_s;
  logic [REGBITS-1:0] instr_rd_s;
  logic               unused_shamt_s;
  ctrl_t              dec_ctrl_s;
  logic               dec_illegal_s;
  logic               uses_rt_s;
  logic               load_use_s;
  logic               jr_hazard_s;
  logic               stall_s;
  logic               illegal_d_s;
  logic [REGBITS-1:0] writereg_e_s;

  logic               valid_q,       valid_d;
  ectrl_t             ectrl_q,       ectrl_d;
  logic [REGBITS-1:0] rs_e_q,        rs_e_d;
  logic [REGBITS-1:0] rt_e_q,        rt_e_d;
  logic [REGBITS-1:0] rd_e_q,        rd_e_d;
  logic               illegal_err_q, illegal_err_d;
  logic [CNTW-1:0]    stall_cnt_q,   stall_cnt_d;

  assign op_s           = instr_d[31:26];
  assign funct_s        = instr_d[5:0];
  assign instr_rs_s     = REGBITS'(instr_d[25:21]);
  assign instr_rt_s     = REGBITS'(instr_d[20:16]);
  assign instr_rd_s     = REGBITS'(instr_d[15:11]);
  assign unused_shamt_s = ^instr_d[10:6];

  ctrl_decode #(
    .EXT_OPS (EXT_OPS)
  ) u_decode (
    .op      (op_s),
    .funct   (funct_s),
    .ctrl    (dec_ctrl_s),
    .illegal (dec_illegal_s)
  );

  // Hazard detection against the instruction in E and the writer in M.
  always_comb begin
    if (ectrl_q.regdst) begin
      writereg_e_s = rd_e_q;
    end else if (ectrl_q.jal) begin
      writereg_e_s = REG_LINK;
    end else begin
      writereg_e_s = rt_e_q;
    end
    uses_rt_s   = uses_rt(op_s, funct_s);
    load_use_s  = valid_q & ectrl_q.memtoreg & (rt_e_q != REG_ZERO) &
                  ((rt_e_q == instr_rs_s) | (uses_rt_s & (rt_e_q == instr_rt_s)));
    // JR reads rs in D, so it must wait out an E writer and a load still in M.
    jr_hazard_s = dec_ctrl_s.jr & (instr_rs_s != REG_ZERO) &
                  ((valid_q & ectrl_q.regwrite & (writereg_e_s == instr_rs_s)) |
                   (memtoreg_m & regwrite_m & (writereg_m == instr_rs_s)));
    stall_s     = instr_valid_d & ~flush_e & (load_use_s | jr_hazard_s);
    illegal_d_s = instr_valid_d & dec_illegal_s;
  end

  // Next-state for the ID/EX register, sticky flag and stall counter.
  always_comb begin
    if (flush_e | stall_s | ~instr_valid_d | dec_illegal_s) begin
      valid_d = 1'b0;
      ectrl_d = E_NOP;
      rs_e_d  = REG_ZERO;
      rt_e_d  = REG_ZERO;
      rd_e_d  = REG_ZERO;
    end else begin
      valid_d = 1'b1;
      ectrl_d = dec_ctrl_s.e;
      rs_e_d  = instr_rs_s;
      rt_e_d  = instr_rt_s;
      rd_e_d  = instr_rd_s;
    end
    illegal_err_d = illegal_err_q | (illegal_d_s & ~flush_e);
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q       <= 1'b0;
      ectrl_q       <= E_NOP;
      rs_e_q        <= REG_ZERO;
      rt_e_q        <= REG_ZERO;
      rd_e_q        <= REG_ZERO;
      illegal_err_q <= 1'b0;
      stall_cnt_q   <= {CNTW{1'b0}};
    end else begin
      valid_q       <= valid_d;
      ectrl_q       <= ectrl_d;
      rs_e_q        <= rs_e_d;
      rt_e_q        <= rt_e_d;
      rd_e_q        <= rd_e_d;
      illegal_err_q <= illegal_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stall_f     = stall_s;
  assign stall_d     = stall_s;
  assign jump_d      = dec_ctrl_s.jump & instr_valid_d & ~stall_s & ~flush_e;
  assign jr_d        = dec_ctrl_s.jr & instr_valid_d & ~stall_s & ~flush_e;
  assign illegal_d   = illegal_d_s;
  assign valid_e     = valid_q;
  assign regwrite_e  = ectrl_q.regwrite;
  assign memtoreg_e  = ectrl_q.memtoreg;
  assign memwrite_e  = ectrl_q.memwrite;
  assign alusrc_e    = ectrl_q.alusrc;
  assign regdst_e    = ectrl_q.regdst;
  assign branch_e    = ectrl_q.branch;
  assign bne_e       = ectrl_q.bne;
  assign jal_e       = ectrl_q.jal;
  assign zeroext_e   = ectrl_q.zeroext;
  assign aluop_e     = ectrl_q.aluop;
  assign rs_e        = rs_e_q;
  assign rt_e        = rt_e_q;
  assign rd_e        = rd_e_q;
  assign writereg_e  = writereg_e_s;
  assign illegal_err = illegal_err_q;
  assign stall_cnt   = stall_cnt_q;

endmodule
